// File: rtl/npn_scan_pkg.sv
// Shared types and constants for the NPN truth-table scanner.
package npn_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_e;

    localparam int PERM_W = 2;
    localparam int N_IN   = 4;

    localparam logic [15:0] DEFAULT_TT    = 16'h16E9;
    localparam logic [7:0]  IDENTITY_PERM = 8'b11_10_01_00;

endpackage

// File: rtl/npn_xform.sv
// Combinational NPN input transform: minterm index -> cell inputs,
// plus a bijection check on the permutation selects.
module npn_xform
    import npn_scan_pkg::*;
(
    input  logic [3:0] idx,
    input  logic [7:0] perm,
    input  logic [3:0] neg_mask,
    output logic [3:0] cell_x,
    output logic       perm_valid
);

    logic [N_IN-1:0]   used;
    logic [PERM_W-1:0] sel;

    always_comb begin
        cell_x = '0;
        used   = '0;
        sel    = '0;
        for (int j = 0; j < N_IN; j++) begin
            sel       = perm[PERM_W*j +: PERM_W];
            cell_x[j] = idx[sel] ^ neg_mask[j];
            used[sel] = 1'b1;
        end
        // Four selects cover all four variables only if none repeats.
        perm_valid = &used;
    end

endmodule

// File: rtl/npn_tt_scanner.sv
// Drives a 4-input cell through all minterms under an NPN transform
// and collects its truth table, comparing it to a reference signature.
module npn_tt_scanner
    import npn_scan_pkg::*;
#(
    parameter int unsigned  SETTLE_CYCLES = 1,
    parameter logic [15:0]  EXPECTED_TT   = DEFAULT_TT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  neg_mask,
    input  logic [7:0]  perm,
    input  logic        out_neg,
    output logic [3:0]  cell_x,
    input  logic        cell_y,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic        perm_err
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  neg_q, neg_d;
    logic [7:0]  perm_q, perm_d;
    logic        oneg_q, oneg_d;
    logic [3:0]  cell_x_q, cell_x_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] tt_q, tt_d;
    logic        match_q, match_d;
    logic        perm_err_q, perm_err_d;

    logic [3:0]  xf_idx;
    logic [7:0]  xf_perm;
    logic [3:0]  xf_neg;
    logic [3:0]  xf_x;
    logic        xf_valid;

    // In IDLE the transform sees the live inputs so pattern(0) and the
    // validity check are available at the accepting edge.
    always_comb begin
        if (state_q == IDLE) begin
            xf_idx  = 4'd0;
            xf_perm = perm;
            xf_neg  = neg_mask;
        end else begin
            xf_idx  = idx_q + 4'd1;
            xf_perm = perm_q;
            xf_neg  = neg_q;
        end
    end

    npn_xform u_xform (
        .idx        (xf_idx),
        .perm       (xf_perm),
        .neg_mask   (xf_neg),
        .cell_x     (xf_x),
        .perm_valid (xf_valid)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        perm_d     = perm_q;
        oneg_d     = oneg_q;
        cell_x_d   = cell_x_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tt_d       = tt_q;
        match_d    = match_q;
        perm_err_d = perm_err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d      = neg_mask;
                    perm_d     = perm;
                    oneg_d     = out_neg;
                    tt_d       = '0;
                    match_d    = 1'b0;
                    perm_err_d = 1'b0;
                    busy_d     = 1'b1;
                    idx_d      = 4'd0;
                    cnt_d      = 4'd0;
                    if (xf_valid) begin
                        cell_x_d = xf_x;
                        state_d  = SCAN;
                    end else begin
                        perm_err_d = 1'b1;
                        state_d    = FINISH;
                    end
                end
            end
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    tt_d[idx_q] = cell_y ^ oneg_q;
                    cnt_d       = 4'd0;
                    if (idx_q != 4'd15) begin
                        idx_d    = idx_q + 4'd1;
                        cell_x_d = xf_x;
                    end else begin
                        cell_x_d = '0;
                        state_d  = FINISH;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                match_d = (tt_q == EXPECTED_TT) && !perm_err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= '0;
            perm_q     <= '0;
            oneg_q     <= 1'b0;
            cell_x_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_q       <= '0;
            match_q    <= 1'b0;
            perm_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            perm_q     <= perm_d;
            oneg_q     <= oneg_d;
            cell_x_q   <= cell_x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tt_q       <= tt_d;
            match_q    <= match_d;
            perm_err_q <= perm_err_d;
        end
    end

    assign cell_x   = cell_x_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt       = tt_q;
    assign match    = match_q;
    assign perm_err = perm_err_q;

endmodule

// File: tb/tb_npn_tt_scanner.sv
// Directed-vector bench for npn_tt_scanner with a behavioural 16'h16E9 cell.
`timescale 1ns/1ps
module tb_npn_tt_scanner;
    import npn_scan_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start1, start3;
    logic [3:0]  neg;
    logic [7:0]  perm;
    logic        oneg;

    logic [3:0]  cx1, cx3;
    logic        cy1, cy3;
    logic        busy1, busy3, done1, done3;
    logic [15:0] tt1, tt3;
    logic        match1, match3, perr1, perr3;

    logic [15:0] cell_tt;
    int          nvec, nerr;
    int          done_cnt1, done_cnt3;
    logic [3:0]  cx_or1;

    assign cy1 = cell_tt[cx1];
    assign cy3 = cell_tt[cx3];

    npn_tt_scanner #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .neg_mask(neg), .perm(perm), .out_neg(oneg),
        .cell_x(cx1), .cell_y(cy1), .busy(busy1), .done(done1),
        .tt(tt1), .match(match1), .perm_err(perr1)
    );

    npn_tt_scanner #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .neg_mask(neg), .perm(perm), .out_neg(oneg),
        .cell_x(cx3), .cell_y(cy3), .busy(busy3), .done(done3),
        .tt(tt3), .match(match3), .perm_err(perr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done1) done_cnt1++;
        if (done3) done_cnt3++;
        cx_or1 = cx_or1 | cx1;
    end

    typedef struct {
        logic [3:0]  neg;
        logic [7:0]  perm;
        logic        oneg;
        logic [15:0] tt;
        logic        m;
        logic        pe;
        int          lat;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accept a start on dut1, scramble config mid-scan, return done latency.
    task automatic run1(output int lat);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("busy_at_accept", 32'(busy1), 32'd1);
        neg  = ~neg;
        perm = ~perm;
        oneg = ~oneg;
        lat  = 0;
        while (lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (done1) break;
        end
    endtask

    initial begin
        int lat;
        int dc;
        nvec    = 0;
        nerr    = 0;
        done_cnt1 = 0;
        done_cnt3 = 0;
        cx_or1  = '0;
        cell_tt = 16'h16E9;
        rst_n   = 1'b0;
        start1  = 1'b0;
        start3  = 1'b0;
        neg     = 4'h0;
        perm    = IDENTITY_PERM;
        oneg    = 1'b0;

        vt[0] = '{4'h0, IDENTITY_PERM, 1'b0, 16'h16E9, 1'b1, 1'b0, 17};
        vt[1] = '{4'h0, IDENTITY_PERM, 1'b1, 16'hE916, 1'b0, 1'b0, 17};
        vt[2] = '{4'h1, IDENTITY_PERM, 1'b0, 16'h29D6, 1'b0, 1'b0, 17};
        vt[3] = '{4'h0, 8'h00,         1'b0, 16'h0000, 1'b0, 1'b1, 1};
        vt[4] = '{4'h0, 8'b11_10_00_01, 1'b0, 16'h16E9, 1'b1, 1'b0, 17};
        vt[5] = '{4'h8, IDENTITY_PERM, 1'b0, 16'hE916, 1'b0, 1'b0, 17};
        vt[6] = '{4'h8, IDENTITY_PERM, 1'b1, 16'h16E9, 1'b1, 1'b0, 17};
        vt[7] = '{4'h0, 8'b00_10_01_00, 1'b1, 16'h0000, 1'b0, 1'b1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_done1", 32'(done1), 0);
        chk("rst_tt1", 32'(tt1), 0);
        chk("rst_match1", 32'(match1), 0);
        chk("rst_perr1", 32'(perr1), 0);
        chk("rst_cx1", 32'(cx1), 0);
        chk("rst_busy3", 32'(busy3), 0);
        chk("rst_tt3", 32'(tt3), 0);
        chk("rst_cx3", 32'(cx3), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            neg    = vt[v].neg;
            perm   = vt[v].perm;
            oneg   = vt[v].oneg;
            cx_or1 = '0;
            dc     = done_cnt1;
            run1(lat);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vt[v].lat));
            chk($sformatf("v%0d_tt", v), 32'(tt1), 32'(vt[v].tt));
            chk($sformatf("v%0d_match", v), 32'(match1), 32'(vt[v].m));
            chk($sformatf("v%0d_perm_err", v), 32'(perr1), 32'(vt[v].pe));
            chk($sformatf("v%0d_busy_end", v), 32'(busy1), 0);
            chk($sformatf("v%0d_cx_end", v), 32'(cx1), 0);
            chk($sformatf("v%0d_cx_cover", v), 32'(cx_or1),
                vt[v].pe ? 32'h0 : 32'hF);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", v), 32'(done1), 0);
            chk($sformatf("v%0d_tt_hold", v), 32'(tt1), 32'(vt[v].tt));
            chk($sformatf("v%0d_match_hold", v), 32'(match1),
                32'(vt[v].m));
            chk($sformatf("v%0d_done_count", v), 32'(done_cnt1 - dc), 1);
        end

        // SETTLE_CYCLES=3 with a second start pulse mid-scan.
        neg    = 4'h0;
        perm   = IDENTITY_PERM;
        oneg   = 1'b0;
        dc     = done_cnt3;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        chk("s3_busy_at_accept", 32'(busy3), 1);
        lat = 0;
        while (lat < 400) begin
            @(posedge clk); #1;
            lat++;
            start3 = (lat == 20);
            if (done3) break;
        end
        start3 = 1'b0;
        chk("s3_latency", 32'(lat), 49);
        chk("s3_tt", 32'(tt3), 32'h16E9);
        chk("s3_match", 32'(match3), 1);
        chk("s3_busy_end", 32'(busy3), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("s3_done_once", 32'(done_cnt3 - dc), 1);
        chk("s3_idle_busy", 32'(busy3), 0);

        // Reset during minterm 7, then a clean rescan.
        neg    = 4'h0;
        perm   = IDENTITY_PERM;
        oneg   = 1'b0;
        dc     = done_cnt1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rs_cx_minterm7", 32'(cx1), 7);
        chk("rs_tt_partial", 32'(tt1), 32'h0069);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rs_busy", 32'(busy1), 0);
        chk("rs_tt", 32'(tt1), 0);
        chk("rs_cx", 32'(cx1), 0);
        chk("rs_done", 32'(done1), 0);
        chk("rs_match", 32'(match1), 0);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("rs_no_done", 32'(done_cnt1 - dc), 0);
        run1(lat);
        chk("rs2_latency", 32'(lat), 17);
        chk("rs2_tt", 32'(tt1), 32'h16E9);
        chk("rs2_match", 32'(match1), 1);
        chk("rs2_perm_err", 32'(perr1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
